myfft_twiddle_fetch: RTL and testbench

MYFFT_TWIDDLE_FETCH -- requirements
Module: myfft_twiddle_fetch

---
 rtl/myfft_twiddle_fetch.sv | 236 +++++++++++++++++++++++
 tb/tb_myfft_twiddle_fetch.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/myfft_twiddle_fetch.sv
// Twiddle fetch engine: strided ROM reads into a 2-entry skid FIFO.
// Optional conjugation of the imaginary half under `MYFFT_TW_CONJ_EN`.
module myfft_twiddle_fetch #(
   parameter int word_width = 16,
   parameter int max_awidth = 6,
   parameter int config_num = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [3:0]              stride_i,
   input  logic [max_awidth-1:0]   count_i,
   input  logic [config_num-1:0]   cfg_i,
`ifdef MYFFT_TW_CONJ_EN
   input  logic                    inv_i,
`endif
   output logic [max_awidth-1:0]   rom_adr_o,
   output logic                    rom_rd_o,
   output logic [config_num-1:0]   rom_cfg_sel_o,
   input  logic [2*word_width-1:0] rom_dat_i,
   output logic [2*word_width-1:0] tw_dat_o,
   output logic                    tw_valid_o,
   input  logic                    tw_ready_i,
   output logic                    tw_last_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int DW = 2 * word_width;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // control state
   state_t                  state_q, state_d;
   logic [max_awidth-1:0]   k_q, k_d;
   logic [max_awidth-1:0]   count_q, count_d;
   logic [3:0]              stride_q, stride_d;
   logic [config_num-1:0]   cfg_q, cfg_d;
`ifdef MYFFT_TW_CONJ_EN
   logic                    conj_q, conj_d;
`endif

   // read pipeline: rdp_q marks ROM data arriving this cycle
   logic                    rdp_q, rdp_d;
   logic                    rdp_last_q, rdp_last_d;

   // 2-entry FIFO
   logic [DW-1:0]           mem_q [2];
   logic [DW-1:0]           mem_d [2];
   logic [1:0]              lst_q, lst_d;
   logic                    wptr_q, wptr_d;
   logic                    rptr_q, rptr_d;
   logic [1:0]              cnt_q, cnt_d;

   // combinational helpers
   logic                    head_valid;
   logic                    head_last;
   logic [DW-1:0]           head_dat;
   logic                    pop;
   logic                    push;
   logic [2:0]              occ;
   logic                    rd;
   logic                    rd_last;
   logic [max_awidth-1:0]   adr;
   logic                    done;

   // FIFO head status and handshake
   always_comb begin
      head_valid = (cnt_q != 2'd0);
      head_last  = lst_q[rptr_q];
      head_dat   = mem_q[rptr_q];
      pop        = head_valid && tw_ready_i;
      push       = rdp_q;
   end

   // read credit: buffered + in flight, net of this cycle's pop
   always_comb begin
      occ     = {1'b0, cnt_q} + {2'b00, rdp_q} - {2'b00, pop};
      rd      = (state_q == FETCH) && (occ < 3'd2);
      rd_last = (k_q == count_q);
      adr     = k_q << stride_q;
      done    = (state_q == DRAIN) && pop && head_last;
   end

   // next-state and datapath control
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      count_d    = count_q;
      stride_d   = stride_q;
      cfg_d      = cfg_q;
`ifdef MYFFT_TW_CONJ_EN
      conj_d     = conj_q;
`endif
      rdp_d      = rd;
      rdp_last_d = rd && rd_last;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d  = FETCH;
               k_d      = '0;
               count_d  = count_i;
               stride_d = stride_i;
               cfg_d    = cfg_i;
`ifdef MYFFT_TW_CONJ_EN
               conj_d   = inv_i;
`endif
            end
         end
         FETCH: begin
            if (rd) begin
               if (rd_last) begin
                  state_d = DRAIN;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FIFO bookkeeping; push and pop may coincide even when full
   always_comb begin
      mem_d  = mem_q;
      lst_d  = lst_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
         mem_d[wptr_q] = rom_dat_i;
         lst_d[wptr_q] = rdp_last_q;
         wptr_d        = ~wptr_q;
      end
      if (pop) begin
         rptr_d = ~rptr_q;
      end
   end

   // control registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         k_q        <= '0;
         count_q    <= '0;
         stride_q   <= '0;
         cfg_q      <= '0;
`ifdef MYFFT_TW_CONJ_EN
         conj_q     <= 1'b0;
`endif
         rdp_q      <= 1'b0;
         rdp_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         count_q    <= count_d;
         stride_q   <= stride_d;
         cfg_q      <= cfg_d;
`ifdef MYFFT_TW_CONJ_EN
         conj_q     <= conj_d;
`endif
         rdp_q      <= rdp_d;
         rdp_last_q <= rdp_last_d;
      end
   end

   // FIFO registers; reset empties the buffer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         lst_q    <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         lst_q    <= lst_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef MYFFT_TW_CONJ_EN
   logic [word_width-1:0] im;
   logic [word_width-1:0] im_neg;
   logic [DW-1:0]         out_dat;

   // saturating negation of the imaginary half
   always_comb begin
      im = head_dat[word_width-1:0];
      if (im == {1'b1, {(word_width-1){1'b0}}}) begin
         im_neg = {1'b0, {(word_width-1){1'b1}}};
      end else begin
         im_neg = '0 - im;
      end
      out_dat = head_dat;
      if (conj_q) begin
         out_dat[word_width-1:0] = im_neg;
      end
   end
`else
   logic [DW-1:0] out_dat;

   // plain pass-through of the ROM word
   always_comb begin
      out_dat = head_dat;
   end
`endif

   // output drive; data gated so idle/reset shows zero
   always_comb begin
      rom_rd_o      = rd;
      rom_adr_o     = rd ? adr : '0;
      rom_cfg_sel_o = cfg_q;
      tw_valid_o    = head_valid;
      tw_dat_o      = head_valid ? out_dat : '0;
      tw_last_o     = head_valid && head_last;
      busy_o        = (state_q != IDLE);
      done_o        = done;
   end

endmodule

// File: tb/tb_myfft_twiddle_fetch.sv
// Directed bench for myfft_twiddle_fetch with a 1-cycle ROM model.
// Build with MYFFT_TW_CONJ_EN to exercise the conjugate path.
module tb_myfft_twiddle_fetch;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [3:0]  stride_i;
   logic [5:0]  count_i;
   logic [2:0]  cfg_i;
   logic        inv;
   logic [5:0]  rom_adr_o;
   logic        rom_rd_o;
   logic [2:0]  rom_cfg_sel_o;
   logic [31:0] rom_dat;
   logic [31:0] tw_dat_o;
   logic        tw_valid_o;
   logic        tw_ready;
   logic        tw_last_o;
   logic        busy_o;
   logic        done_o;

   int errors;
   int checks;
   int cyc;
   int start_cyc;
   int first_vcyc;
   int done_cnt;
   int adr_log[$];
   logic [31:0] dat_log[$];
   logic last_log[$];
   int xfer_cyc[$];
   logic        ovr_en;
   logic [31:0] ovr_word;

   myfft_twiddle_fetch #(
      .word_width(16),
      .max_awidth(6),
      .config_num(3)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start_i),
      .stride_i     (stride_i),
      .count_i      (count_i),
      .cfg_i        (cfg_i),
`ifdef MYFFT_TW_CONJ_EN
      .inv_i        (inv),
`endif
      .rom_adr_o    (rom_adr_o),
      .rom_rd_o     (rom_rd_o),
      .rom_cfg_sel_o(rom_cfg_sel_o),
      .rom_dat_i    (rom_dat),
      .tw_dat_o     (tw_dat_o),
      .tw_valid_o   (tw_valid_o),
      .tw_ready_i   (tw_ready),
      .tw_last_o    (tw_last_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] romf(input int a);
      logic [15:0] a16;
      a16 = 16'(a);
      return {16'h1000 + a16, 16'hA000 ^ a16};
   endfunction

   // ROM model: data valid exactly one cycle after a read
   always @(posedge clk) begin
      if (rom_rd_o)
         rom_dat <= ovr_en ? ovr_word : romf(int'(rom_adr_o));
      else
         rom_dat <= 32'hDEAD_BEEF;
   end

   // observation log sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (rom_rd_o) adr_log.push_back(int'(rom_adr_o));
         if (tw_valid_o && tw_ready) begin
            dat_log.push_back(tw_dat_o);
            last_log.push_back(tw_last_o);
            xfer_cyc.push_back(cyc);
         end
         if (tw_valid_o && first_vcyc < 0) first_vcyc = cyc;
         if (done_o) done_cnt++;
      end
   end

   task automatic clear_logs();
      adr_log.delete();
      dat_log.delete();
      last_log.delete();
      xfer_cyc.delete();
      done_cnt = 0;
      first_vcyc = -1;
   endtask

   task automatic do_start(input logic [3:0] s, input logic [5:0] c,
                           input logic [2:0] g);
      @(posedge clk); #1;
      start_i  = 1'b1;
      stride_i = s;
      count_i  = c;
      cfg_i    = g;
      start_cyc = cyc;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output bit to);
      to = 1'b1;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (done_cnt > 0) begin
            to = 1'b0;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({rom_adr_o, rom_rd_o, rom_cfg_sel_o, tw_dat_o, tw_valid_o,
           tw_last_o, busy_o, done_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: adr=%0d rd=%b cfg=%b dat=%h v=%b l=%b b=%b d=%b, required all 0",
                  rom_adr_o, rom_rd_o, rom_cfg_sel_o, tw_dat_o, tw_valid_o,
                  tw_last_o, busy_o, done_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || tw_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: busy=%b valid=%b, required 0 0",
                  busy_o, tw_valid_o);
      end
   endtask

   task automatic test_stride1();
      int exp_a[4] = '{0, 2, 4, 6};
      bit to;
      bit bad;
      clear_logs();
      tw_ready = 1'b1;
      do_start(4'd1, 6'd3, 3'b001);
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL s1_busy: got %b, required 1", busy_o);
      end
      wait_done(40, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL s1_timeout: done_o not seen, required within 40 cycles");
      end
      checks++;
      bad = (adr_log.size() != 4);
      for (int i = 0; i < 4 && !bad; i++) bad = (adr_log[i] != exp_a[i]);
      if (bad) begin
         errors++;
         $display("FAIL s1_addr: got %p, required 0,2,4,6", adr_log);
      end
      checks++;
      bad = (dat_log.size() != 4);
      for (int i = 0; i < 4 && !bad; i++)
         bad = (dat_log[i] !== romf(exp_a[i])) ||
               (last_log[i] !== (i == 3));
      if (bad) begin
         errors++;
         $display("FAIL s1_data: got %p last %p, required 4 words of addr 0,2,4,6 last on 4th",
                  dat_log, last_log);
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL s1_done: got %0d pulses, required 1", done_cnt);
      end
      checks++;
      if (first_vcyc - start_cyc !== 3) begin
         errors++;
         $display("FAIL s1_latency: got %0d, required 3", first_vcyc - start_cyc);
      end
      checks++;
      if (xfer_cyc.size() != 4 || xfer_cyc[3] - xfer_cyc[0] != 3) begin
         errors++;
         $display("FAIL s1_throughput: cycles %p, required 4 consecutive", xfer_cyc);
      end
      checks++;
      if (busy_o !== 1'b0 || rom_cfg_sel_o !== 3'b001) begin
         errors++;
         $display("FAIL s1_end_state: busy=%b cfg=%b, required 0 001",
                  busy_o, rom_cfg_sel_o);
      end
   endtask

   task automatic test_wrap();
      int exp_a[10] = '{0, 8, 16, 24, 32, 40, 48, 56, 0, 8};
      bit to;
      bit bad;
      clear_logs();
      tw_ready = 1'b1;
      do_start(4'd3, 6'd9, 3'b010);
      wait_done(60, to);
      checks++;
      bad = to || (adr_log.size() != 10);
      for (int i = 0; i < 10 && !bad; i++) bad = (adr_log[i] != exp_a[i]);
      if (bad) begin
         errors++;
         $display("FAIL wrap_addr: got %p timeout=%b, required 0,8..56,0,8",
                  adr_log, to);
      end
      checks++;
      bad = (dat_log.size() != 10);
      for (int i = 0; i < 10 && !bad; i++)
         bad = (dat_log[i] !== romf(exp_a[i])) ||
               (last_log[i] !== (i == 9));
      if (bad) begin
         errors++;
         $display("FAIL wrap_data: got %p, required words of wrapped addrs", dat_log);
      end
      checks++;
      if (rom_cfg_sel_o !== 3'b010) begin
         errors++;
         $display("FAIL wrap_cfg: got %b, required 010", rom_cfg_sel_o);
      end
   endtask

   task automatic test_backpressure();
      bit to;
      bit bad;
      clear_logs();
      tw_ready = 1'b0;
      do_start(4'd0, 6'd5, 3'b001);
      repeat (9) @(negedge clk);
      checks++;
      if (adr_log.size() != 2) begin
         errors++;
         $display("FAIL bp_reads: got %0d reads, required 2", adr_log.size());
      end
      checks++;
      if (tw_valid_o !== 1'b1 || tw_dat_o !== romf(0)) begin
         errors++;
         $display("FAIL bp_head: valid=%b dat=%h, required 1 %h",
                  tw_valid_o, tw_dat_o, romf(0));
      end
      @(posedge clk); #1;
      tw_ready = 1'b1;
      wait_done(40, to);
      checks++;
      bad = to || (dat_log.size() != 6);
      for (int i = 0; i < 6 && !bad; i++)
         bad = (dat_log[i] !== romf(i)) || (last_log[i] !== (i == 5));
      if (bad) begin
         errors++;
         $display("FAIL bp_data: got %p timeout=%b, required addr 0..5 in order",
                  dat_log, to);
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL bp_done: got %0d, required 1", done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat = 8'b1011_0010;
      bit to;
      bit bad;
      clear_logs();
      tw_ready = 1'b1;
      do_start(4'd0, 6'd5, 3'b100);
      to = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         tw_ready = pat[i % 8];
         @(negedge clk);
         if (done_cnt > 0) begin
            to = 1'b0;
            break;
         end
      end
      tw_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      bad = to || (dat_log.size() != 6);
      for (int i = 0; i < 6 && !bad; i++)
         bad = (dat_log[i] !== romf(i)) || (last_log[i] !== (i == 5));
      if (bad) begin
         errors++;
         $display("FAIL b2b_data: got %p timeout=%b, required addr 0..5 in order",
                  dat_log, to);
      end
      checks++;
      if (adr_log.size() != 6 || done_cnt !== 1) begin
         errors++;
         $display("FAIL b2b_counts: reads=%0d done=%0d, required 6 1",
                  adr_log.size(), done_cnt);
      end
   endtask

   task automatic test_midrun_reset();
      int exp_a[3] = '{0, 4, 8};
      bit to;
      bit bad;
      clear_logs();
      tw_ready = 1'b1;
      do_start(4'd1, 6'd7, 3'b010);
      to = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dat_log.size() >= 2) begin
            to = 1'b0;
            break;
         end
      end
      checks++;
      if (to || busy_o !== 1'b1 || rom_rd_o !== 1'b1) begin
         errors++;
         $display("FAIL mr_pre: timeout=%b busy=%b rd=%b, required 0 1 1",
                  to, busy_o, rom_rd_o);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({rom_adr_o, rom_rd_o, rom_cfg_sel_o, tw_dat_o, tw_valid_o,
           tw_last_o, busy_o, done_o} !== '0) begin
         errors++;
         $display("FAIL mr_outputs: adr=%0d rd=%b cfg=%b dat=%h v=%b l=%b b=%b d=%b, required all 0",
                  rom_adr_o, rom_rd_o, rom_cfg_sel_o, tw_dat_o, tw_valid_o,
                  tw_last_o, busy_o, done_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tw_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL mr_discard: valid=%b busy=%b, required 0 0",
                  tw_valid_o, busy_o);
      end
      clear_logs();
      do_start(4'd2, 6'd2, 3'b100);
      wait_done(30, to);
      checks++;
      bad = to || (adr_log.size() != 3) || (dat_log.size() != 3);
      for (int i = 0; i < 3 && !bad; i++)
         bad = (adr_log[i] != exp_a[i]) || (dat_log[i] !== romf(exp_a[i])) ||
               (last_log[i] !== (i == 2));
      if (bad || done_cnt !== 1) begin
         errors++;
         $display("FAIL mr_rerun: addr %p data %p done=%0d, required 0,4,8 done 1",
                  adr_log, dat_log, done_cnt);
      end
   endtask

   task automatic test_start_busy();
      int exp_a[4] = '{0, 2, 4, 6};
      bit to;
      bit bad;
      clear_logs();
      tw_ready = 1'b1;
      do_start(4'd1, 6'd3, 3'b010);
      do_start(4'd0, 6'd1, 3'b100);
      wait_done(40, to);
      checks++;
      bad = to || (adr_log.size() != 4) || (dat_log.size() != 4);
      for (int i = 0; i < 4 && !bad; i++)
         bad = (adr_log[i] != exp_a[i]) || (dat_log[i] !== romf(exp_a[i]));
      if (bad) begin
         errors++;
         $display("FAIL sb_run: addr %p data %p, required original run 0,2,4,6",
                  adr_log, dat_log);
      end
      checks++;
      if (rom_cfg_sel_o !== 3'b010 || done_cnt !== 1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL sb_state: cfg=%b done=%0d busy=%b, required 010 1 0",
                  rom_cfg_sel_o, done_cnt, busy_o);
      end
   endtask

   task automatic test_count0();
      bit to;
      clear_logs();
      tw_ready = 1'b1;
      do_start(4'd2, 6'd0, 3'b001);
      wait_done(20, to);
      checks++;
      if (to || adr_log.size() != 1 || dat_log.size() != 1) begin
         errors++;
         $display("FAIL c0_count: reads=%0d xfers=%0d timeout=%b, required 1 1 0",
                  adr_log.size(), dat_log.size(), to);
      end else begin
         checks++;
         if (dat_log[0] !== romf(0) || last_log[0] !== 1'b1) begin
            errors++;
            $display("FAIL c0_data: got %h last=%b, required %h last=1",
                     dat_log[0], last_log[0], romf(0));
         end
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL c0_done: got %0d, required 1", done_cnt);
      end
   endtask

   task automatic test_conj();
      bit to;
      logic [31:0] req;
      clear_logs();
      tw_ready = 1'b1;
      ovr_en   = 1'b1;
      ovr_word = 32'h4000_8000;
`ifdef MYFFT_TW_CONJ_EN
      inv = 1'b1;
      req = 32'h4000_7FFF;
`else
      req = 32'h4000_8000;
`endif
      do_start(4'd0, 6'd0, 3'b001);
      wait_done(20, to);
      checks++;
      if (to || dat_log.size() != 1 || dat_log[0] !== req) begin
         errors++;
         $display("FAIL conj_word: got %p timeout=%b, required %h",
                  dat_log, to, req);
      end
      ovr_en = 1'b0;
      inv    = 1'b0;
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      cyc      = 0;
      rst      = 1'b1;
      start_i  = 1'b0;
      stride_i = '0;
      count_i  = '0;
      cfg_i    = '0;
      inv      = 1'b0;
      tw_ready = 1'b1;
      ovr_en   = 1'b0;
      ovr_word = '0;
      clear_logs();
      test_reset();
      test_stride1();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_midrun_reset();
      test_start_busy();
      test_count0();
      test_conj();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
